axi_lite_sram: RTL

AXI4-Lite responder (slave) backing data memory for the multicycle core: it terminates the `mem_*` master port emerging from the arbiter and services independent read (AR/R) and write (AW/W/B) channels against an internal word array. Programmable per-channel response latency lets the bench and the core exercise multi-cycle handshakes. Single outstanding transaction per channel; reads and writes proceed concurrently.

---
 rtl/axi_lite_sram.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_sram.sv
// AXI4-Lite responder over an internal 32-bit word array. The read (AR/R) and
// write (AW/W/B) channels run independently, each with a programmable response latency.
module axi_lite_sram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned READ_LAT  = 0,
  parameter int unsigned WRITE_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN        = 33'(DEPTH) << 2;
  localparam logic [3:0]  R_LAT       = 4'(READ_LAT);
  localparam logic [3:0]  W_LAT       = 4'(WRITE_LAT);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] { R_IDLE, R_WAIT, R_RESP } r_state_e;
  typedef enum logic [1:0] { W_IDLE, W_WAIT, W_RESP } w_state_e;

  logic [31:0] mem [DEPTH];

  // The lower bound is checked explicitly so addresses below the base cannot wrap into range.
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  // ---------------------------------------------------------------- read channel
  r_state_e         r_state_q, r_state_d;
  logic [3:0]       r_cnt_q, r_cnt_d;
  logic [31:0]      r_addr_q, r_addr_d;
  logic [31:0]      r_ram_q;
  logic             r_hit_q;
  logic [1:0]       rresp_q;
  logic             ar_fire, r_load, r_hit;
  logic [31:0]      r_sel_addr, r_off;
  logic [IDX_W-1:0] r_idx;

  assign arready = rst && (r_state_q == R_IDLE);
  assign ar_fire = arvalid && arready;
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = r_hit_q ? r_ram_q : 32'h0;
  assign rresp   = rresp_q;

  // With zero latency the lookup happens on the AR handshake edge, before r_addr_q is valid.
  assign r_sel_addr = (r_state_q == R_IDLE) ? araddr : r_addr_q;
  assign r_off      = r_sel_addr - BASE_ADDR;
  assign r_idx      = r_off[IDX_W+1:2];
  assign r_hit      = in_range(r_sel_addr);

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_addr_d = araddr;
          r_cnt_d  = R_LAT;
          if (R_LAT != 4'd0) begin
            r_state_d = R_WAIT;
          end else begin
            r_state_d = R_RESP;
            r_load    = 1'b1;
          end
        end
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - 4'd1;
        if (r_cnt_q <= 4'd1) begin
          r_state_d = R_RESP;
          r_load    = 1'b1;
        end
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      r_addr_q  <= 32'h0;
      r_hit_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      if (r_load) begin
        r_hit_q <= r_hit;
        rresp_q <= r_hit ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Plain registered array read; a same-edge write lands after this sample.
  always_ff @(posedge clk) begin
    if (r_load) begin
      r_ram_q <= mem[r_idx];
    end
  end

  // --------------------------------------------------------------- write channel
  w_state_e         w_state_q, w_state_d;
  logic [3:0]       w_cnt_q, w_cnt_d;
  logic             aw_cap_q, aw_cap_d;
  logic             w_cap_q, w_cap_d;
  logic [31:0]      w_addr_q, w_addr_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  logic [1:0]       bresp_q;
  logic             aw_fire, w_fire, w_commit, w_hit;
  logic [31:0]      w_sel_addr, w_sel_data, w_off;
  logic [3:0]       w_sel_strb;
  logic [IDX_W-1:0] w_idx;

  assign awready = rst && (w_state_q == W_IDLE) && !aw_cap_q;
  assign wready  = rst && (w_state_q == W_IDLE) && !w_cap_q;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;

  // A beat arriving on the completing edge is used directly; otherwise the captured copy.
  assign w_sel_addr = aw_fire ? awaddr      : w_addr_q;
  assign w_sel_data = w_fire  ? wdata       : w_data_q;
  assign w_sel_strb = w_fire  ? wstrb[3:0]  : w_strb_q;
  assign w_off      = w_sel_addr - BASE_ADDR;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_hit      = in_range(w_sel_addr);

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_cap_d = 1'b1;
          w_addr_d = awaddr;
        end
        if (w_fire) begin
          w_cap_d  = 1'b1;
          w_data_d = wdata;
          w_strb_d = wstrb[3:0];
        end
        if ((aw_cap_q || aw_fire) && (w_cap_q || w_fire)) begin
          w_cnt_d = W_LAT;
          if (W_LAT != 4'd0) begin
            w_state_d = W_WAIT;
          end else begin
            w_state_d = W_RESP;
            w_commit  = 1'b1;
          end
        end
      end
      W_WAIT: begin
        w_cnt_d = w_cnt_q - 4'd1;
        if (w_cnt_q <= 4'd1) begin
          w_state_d = W_RESP;
          w_commit  = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          aw_cap_d  = 1'b0;
          w_cap_d   = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 4'd0;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      w_addr_q  <= 32'h0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      if (w_commit) begin
        bresp_q <= w_hit ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Gated by rst so a reset landing on the commit edge abandons the write.
  always_ff @(posedge clk) begin
    if (rst && w_commit && w_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (w_sel_strb[k]) begin
          mem[w_idx][8*k +: 8] <= w_sel_data[8*k +: 8];
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{r_off[31:IDX_W+2], r_off[1:0], w_off[31:IDX_W+2], w_off[1:0], wstrb[7:4]};

endmodule
